// File: rtl/serial_tx_sequencer.sv
// Parallel-to-serial transmitter: loads a word on start, shifts it out one bit
// per cycle with a valid strobe, then pulses done for one cycle.
module serial_tx_sequencer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done
);

  localparam int            CW      = $clog2(WIDTH);
  localparam int            OUT_IDX = MSB_FIRST ? WIDTH-1 : 0;
  localparam logic [CW-1:0] LAST    = CW'(WIDTH-1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (cnt == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Counter holds at LAST on the final shift so it never wraps mid-transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      sreg <= '0;
      cnt  <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          sreg <= din;
          cnt  <= '0;
        end
        SHIFT: begin
          sreg <= MSB_FIRST ? (sreg << 1) : (sreg >> 1);
          if (cnt != LAST) cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign sout_valid = (state == SHIFT);
  assign sout       = (state == SHIFT) ? sreg[OUT_IDX] : 1'b0;
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);

endmodule

// File: doc/serial_tx_sequencer.md
SERIAL_TX_SEQUENCER -- requirements
Module: serial_tx_sequencer

Interface
REQ-001 The module SHALL have parameter WIDTH, default 4, giving the parallel word width in bits; legal range 2..16.
REQ-002 The module SHALL have parameter MSB_FIRST, default 0, where 0 means LSB shifted out first and 1 means MSB shifted out first.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have port start, input, 1 bit: request to begin transmitting din.
REQ-006 The module SHALL have port din, input, WIDTH bits: parallel word, sampled only when a start is accepted.
REQ-007 The module SHALL have port sout, output, 1 bit: serial data bit.
REQ-008 The module SHALL have port sout_valid, output, 1 bit: sout carries a payload bit this cycle.
REQ-009 The module SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-010 The module SHALL have port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-011 The module SHALL implement three states: IDLE, SHIFT and DONE.
REQ-012 In IDLE, a rising edge with start=1 SHALL accept the request: load the shift register with din, clear the bit counter to 0, and enter SHIFT.
REQ-013 In IDLE, a rising edge with start=0 SHALL leave the state and shift register unchanged.
REQ-014 In SHIFT, sout_valid SHALL be 1.
REQ-015 In SHIFT, sout SHALL be the shift register bit selected by MSB_FIRST: bit 0 when 0, bit WIDTH-1 when 1.
REQ-016 Each rising edge in SHIFT SHALL shift the register one position toward the output end (zero fill) and increment the counter.
REQ-017 The rising edge on which the counter equals WIDTH-1 SHALL move the state to DONE.
REQ-018 SHIFT SHALL therefore last exactly WIDTH cycles.
REQ-019 In DONE, done SHALL be 1 for exactly one cycle, and the next rising edge SHALL return the state to IDLE.
REQ-020 Latency SHALL be as follows for start accepted at edge k:
- sout_valid high for cycles k+1 .. k+WIDTH;
- done high in cycle k+WIDTH+1;
- busy low again from cycle k+WIDTH+2.
REQ-021 start SHALL be ignored in SHIFT and DONE, with no queuing; din changes during SHIFT SHALL NOT affect the transmitted bits.
REQ-022 A start held high continuously SHALL be re-accepted at the first edge spent in IDLE, giving back-to-back words separated by one DONE cycle and one IDLE cycle.
REQ-023 Outside SHIFT, sout and sout_valid SHALL be 0.
REQ-024 All outputs SHALL be functions of registered state only, with no combinational path from start or din to any output.
REQ-025 The counter SHALL be wide enough to count to WIDTH-1 and SHALL never wrap within a transfer.

Reset
REQ-026 A rising edge with reset=1 SHALL force state IDLE, shift register 0 and counter 0.
REQ-027 From the cycle following a reset edge, sout, sout_valid, busy and done SHALL all be 0.
REQ-028 reset SHALL take priority over start at the same edge, and that start SHALL NOT be accepted.
REQ-029 A reset asserted mid-SHIFT or in DONE SHALL abort the transfer with no done pulse.
REQ-030 After reset deasserts, the first edge with start=1 SHALL be accepted normally.

Verification
REQ-031 The bench SHALL cover WIDTH=4, MSB_FIRST=0, din=4'b1011, start pulsed at edge k -> sout sequence 1,1,0,1 in cycles k+1..k+4 with sout_valid=1, done=1 only in cycle k+5, busy=0 in cycle k+6.
REQ-032 The bench SHALL cover MSB_FIRST=1, din=4'b1011 -> sout sequence 1,0,1,1.
REQ-033 The bench SHALL cover a second start pulse and din=4'b0000 applied during SHIFT -> original word transmitted unaltered and no second transfer starts.
REQ-034 The bench SHALL cover start held high for 20 cycles with din=4'b0110 -> repeated 0,1,1,0 frames, each followed by one done cycle and one idle cycle, period 6.
REQ-035 The bench SHALL cover reset asserted after the 2nd shifted bit -> next cycle all outputs 0, no done pulse, and a following start transmits the new din in full.
REQ-036 The bench SHALL cover reset=1 and start=1 at the same edge -> state stays IDLE and busy=0 in the next cycle.
